// File: rtl/t64_intc_pkg.sv
// rtl/t64_intc_pkg.sv - shared register map, FSM state type and VEC layout for t64_intc
package t64_intc_pkg;

    localparam logic [2:0] REG_MASK = 3'd0;
    localparam logic [2:0] REG_PEND = 3'd1;
    localparam logic [2:0] REG_VEC  = 3'd2;
    localparam logic [2:0] REG_EOI  = 3'd3;
    localparam logic [2:0] REG_EDGE = 3'd4;

    localparam int VEC_VALID_BIT = 63;
    localparam int IDX_W         = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_INSERV = 2'd2
    } intc_state_t;

endpackage

// File: rtl/t64_intc_prio_enc.sv
// rtl/t64_intc_prio_enc.sv - lowest-index-wins priority encoder for interrupt candidates
module prio_enc
    import t64_intc_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0]  req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan downwards so the lowest set index is the last one assigned.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t64_intc.sv
// rtl/t64_intc.sv - single-level interrupt controller with mask, edge/level pending and in-service vector
module t64_intc
    import t64_intc_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [2:0]      addr,
    input  logic [63:0]     wdata,
    input  logic            wr,
    output logic [63:0]     rdata,
    output logic            intr,
    input  logic            intack
);

    logic [NSRC-1:0]  mask;
    logic [NSRC-1:0]  edge_mode;
    logic [NSRC-1:0]  pend;
    logic [NSRC-1:0]  src_q;
    logic [IDX_W-1:0] vec_idx;
    logic             vec_valid;
    intc_state_t      state;
    intc_state_t      next_state;

    logic [NSRC-1:0]  cand;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             ack;
    logic             eoi;
    logic [NSRC-1:0]  w1c;
    logic [NSRC-1:0]  ack_clr;
    logic [NSRC-1:0]  pend_next;
    logic             unused_wdata;

    assign unused_wdata = ^wdata[63:NSRC];

    assign cand = pend & mask;

    prio_enc #(.NSRC(NSRC)) u_prio_enc (
        .req   (cand),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign ack     = (state == ST_REQ) && win_valid && intack;
    assign eoi     = (state == ST_INSERV) && wr && (addr == REG_EOI);
    assign w1c     = (wr && addr == REG_PEND) ? wdata[NSRC-1:0] : '0;
    assign ack_clr = ack ? ((NSRC'(1) << win_idx) & edge_mode) : '0;

    // Edge bits: a fresh rise wins over any clear in the same cycle; level bits track src.
    assign pend_next = (edge_mode & ((src & ~src_q) | (pend & ~(w1c | ack_clr))))
                     | (~edge_mode & src);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (win_valid) next_state = ST_REQ;
            ST_REQ: begin
                if (!win_valid)  next_state = ST_IDLE;
                else if (intack) next_state = ST_INSERV;
            end
            ST_INSERV: if (eoi) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // intr is held only while REQ persists, so it drops on the edge after ack or withdrawal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            intr <= 1'b0;
        end else begin
            intr <= (state == ST_REQ) && (next_state == ST_REQ);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask      <= '0;
            edge_mode <= '0;
            pend      <= '0;
            src_q     <= '0;
            vec_idx   <= '0;
            vec_valid <= 1'b0;
        end else begin
            src_q <= src;
            pend  <= pend_next;
            if (wr && addr == REG_MASK) mask      <= wdata[NSRC-1:0];
            if (wr && addr == REG_EDGE) edge_mode <= wdata[NSRC-1:0];
            if (ack) begin
                vec_idx   <= win_idx;
                vec_valid <= 1'b1;
            end else if (eoi) begin
                vec_idx   <= '0;
                vec_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_MASK: rdata = 64'(mask);
            REG_PEND: rdata = 64'(pend);
            REG_VEC: begin
                rdata[IDX_W-1:0]     = vec_idx;
                rdata[VEC_VALID_BIT] = vec_valid;
            end
            REG_EDGE: rdata = 64'(edge_mode);
            default:  rdata = '0;
        endcase
    end

endmodule
